ex_mem_lsu: RTL and testbench
=============================

EX_MEM_LSU -- requirements
Module: ex_mem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, effective/bus address width (>=32).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, bus wait limit before fault; 0 = timeout disabled.
REQ-003 SHALL have parameter ALIGN_CHECK, default 1; 1 = misaligned access faults, 0 = no check (address low bits select lanes only).
REQ-004 Ports: clk in 1, clock; rst_n in 1, async active-low reset; one clock only.
REQ-005 Ports: dmem_din in 64, read data; dmem_dout out 64, write data; dmem_addr out ADDR_W, doubleword-aligned bus address; dmem_be out 8, byte enables, bit i = dmem_dout[8i+7:8i].
REQ-006 Ports: dmem_width out 2, access-size code; dmem_rstrobe out 1, read request; dmem_wstrobe out 1, write request; dmem_cycle_complete in 1, bus done.
REQ-007 Ports: base in 64, R1; data in 64, R2; offset in 32, immediate; out out 64, result.
REQ-008 Ports: ex_enable in 1, dispatch; ex_busy out 1; rd_in_rn in 6; unit in 3; op in 2.
REQ-009 Ports: rd_out_rn out 6; valid out 1; stall in 1, commit back-pressure; fault out 1; fault_cause out 2 (1 misalign, 2 timeout); fault_addr out ADDR_W.

Function
REQ-010 Decode at ex_enable: unit 4 = load zero-extend, unit 5 op!=0 = load sign-extend, unit 5 op 0 = LUI, unit 6 = store; other unit codes SHALL be ignored (no strobe, no valid).
REQ-011 Size by op: 0=8 bytes, 1=4, 2=2, 3=1; dmem_width SHALL equal latched op.
REQ-012 Effective address EA = (base + sign-extended offset) truncated to ADDR_W; dmem_addr = EA with bits [2:0] cleared.
REQ-013 Lanes big-endian: byte at EA[2:0]=k occupies bits [63-8k:56-8k]; load extracts the size-aligned field at k, zero- or sign-extends to 64.
REQ-014 Store: dmem_dout = low size bytes of data replicated across all lanes; dmem_be set only for the accessed bytes.
REQ-015 States IDLE, READ_WAIT, WRITE_WAIT, HOLD; ex_enable sampled only in IDLE.
REQ-016 IDLE + load/store, aligned: drive address/data/be, pulse strobe one cycle, go READ_WAIT/WRITE_WAIT.
REQ-017 WAIT: on dmem_cycle_complete -> result register loaded, valid=1 next cycle; load rd_out_rn = latched rd_in_rn, store rd_out_rn = 0.
REQ-018 LUI: no bus activity; out = {offset, 32'h0}, valid, rd_out_rn = rd_in_rn one cycle after ex_enable.
REQ-019 ALIGN_CHECK=1 and EA[2:0] not a multiple of size: no strobe; one cycle later valid=1, fault=1, fault_cause=1, fault_addr=EA, rd_out_rn=0.
REQ-020 TIMEOUT_CYCLES>0: wait counter clears on strobe; reaching TIMEOUT_CYCLES without complete -> fault cause 2, fault_addr=EA, valid=1, rd_out_rn=0; later complete ignored.
REQ-021 valid is one-cycle unless stall=1; while valid&&stall, state HOLD, out/rd_out_rn/fault held stable; released the cycle after stall falls.
REQ-022 ex_busy = ex_enable | (state!=IDLE) | (valid & stall), combinational.
REQ-023 complete and timeout expiry in the same cycle: complete wins.
REQ-024 ex_enable while not IDLE is a protocol violation; SHALL be ignored.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, counter 0, all outputs 0, including mid-transaction; in-flight bus cycle is abandoned.
REQ-026 First ex_enable SHALL be accepted on the first clk edge after rst_n deasserts.

Structure
REQ-027 Unit codes, size codes, fault causes and state encodings SHALL live in shared package raisin64_ex_pkg.
REQ-028 Lane extract/insert and be generation SHALL be combinational sub-module ex_mem_lane.

Verification
REQ-029 LW sign-extend (unit 5, op 1), base 0x1000, offset 4, din 0x00000000_80000001 -> out 0xFFFFFFFF_80000001, rd_out_rn as dispatched.
REQ-030 SB (unit 6, op 3), EA 0x2003, data 0xAB -> dmem_addr 0x2000, be 0x10, dmem_dout 0xABABABAB_ABABABAB, valid rd_out_rn 0.
REQ-031 LH EA 0x3001, ALIGN_CHECK=1 -> no rstrobe, fault 1, cause 1, fault_addr 0x3001 one cycle after enable.
REQ-032 TIMEOUT_CYCLES=4, read never completes -> fault cause 2 on 4th wait cycle, state IDLE, ex_busy low after.
REQ-033 LUI offset 0x12345678 with stall held 3 cycles -> out 0x12345678_00000000 stable, valid high 3 cycles, ex_busy high throughout.
REQ-034 rst_n pulse during READ_WAIT -> all outputs 0 immediately; next load completes normally.

Source files
------------

// File: rtl/raisin64_ex_pkg.sv
// Shared encodings for the Raisin64 execute-stage load/store unit:
// unit codes, access sizes, fault causes and FSM states.
package raisin64_ex_pkg;

  localparam logic [2:0] UNIT_LOAD_Z = 3'd4;
  localparam logic [2:0] UNIT_LOAD_S = 3'd5;
  localparam logic [2:0] UNIT_STORE  = 3'd6;

  localparam logic [1:0] SIZE_D = 2'd0;
  localparam logic [1:0] SIZE_W = 2'd1;
  localparam logic [1:0] SIZE_H = 2'd2;
  localparam logic [1:0] SIZE_B = 2'd3;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_HOLD       = 2'd3
  } lsu_state_e;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_D:  return 3'b111;
      SIZE_W:  return 3'b011;
      SIZE_H:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_D:  return 4'd8;
      SIZE_W:  return 4'd4;
      SIZE_H:  return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic [7:0] size_be(input logic [1:0] size);
    case (size)
      SIZE_D:  return 8'hFF;
      SIZE_W:  return 8'h0F;
      SIZE_H:  return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_lane.sv
// Big-endian lane steering: load field extraction with zero/sign extension,
// store data replication and byte-enable generation.
module ex_mem_lane
  import raisin64_ex_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  lane,
  input  logic        sext,
  input  logic [63:0] load_din,
  input  logic [63:0] store_din,
  output logic [63:0] load_data,
  output logic [63:0] store_data,
  output logic [7:0]  be
);

  logic [2:0]  lane_a_s;
  logic [3:0]  shift_s;
  logic [63:0] field_s;

  // Byte k sits at bits [63-8k:56-8k], so the field's right shift counts bytes past its last lane.
  always_comb begin
    lane_a_s = lane & ~size_mask(size);
    shift_s  = 4'd8 - {1'b0, lane_a_s} - size_bytes(size);
    field_s  = load_din >> {shift_s, 3'b000};
    be       = size_be(size) << shift_s;
    case (size)
      SIZE_W: begin
        load_data  = sext ? {{32{field_s[31]}}, field_s[31:0]} : {32'h0, field_s[31:0]};
        store_data = {2{store_din[31:0]}};
      end
      SIZE_H: begin
        load_data  = sext ? {{48{field_s[15]}}, field_s[15:0]} : {48'h0, field_s[15:0]};
        store_data = {4{store_din[15:0]}};
      end
      SIZE_B: begin
        load_data  = sext ? {{56{field_s[7]}}, field_s[7:0]} : {56'h0, field_s[7:0]};
        store_data = {8{store_din[7:0]}};
      end
      default: begin
        load_data  = field_s;
        store_data = store_din;
      end
    endcase
  end

endmodule

// File: rtl/ex_mem_lsu.sv
// Execute-stage load/store unit: address generation, alignment check,
// single-outstanding bus access with timeout, and commit hand-off with stall.
module ex_mem_lsu
  import raisin64_ex_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ALIGN_CHECK    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       dmem_din,
  output logic [63:0]       dmem_dout,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_be,
  output logic [1:0]        dmem_width,
  output logic              dmem_rstrobe,
  output logic              dmem_wstrobe,
  input  logic              dmem_cycle_complete,
  input  logic [63:0]       base,
  input  logic [63:0]       data,
  input  logic [31:0]       offset,
  output logic [63:0]       out,
  input  logic              ex_enable,
  output logic              ex_busy,
  input  logic [5:0]        rd_in_rn,
  input  logic [2:0]        unit,
  input  logic [1:0]        op,
  output logic [5:0]        rd_out_rn,
  output logic              valid,
  input  logic              stall,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic [ADDR_W-1:0] fault_addr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_r;
  logic [1:0]        op_r;
  logic              sext_r;
  logic [5:0]        rd_r;
  logic [ADDR_W-1:0] ea_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [63:0]       out_r, dout_r;
  logic [ADDR_W-1:0] addr_r, fault_addr_r;
  logic [7:0]        be_r;
  logic [1:0]        width_r, cause_r;
  logic [5:0]        rd_out_r;
  logic              valid_r, fault_r, rstrobe_r, wstrobe_r;

  logic [63:0]       ea_full_s;
  logic [ADDR_W-1:0] ea_s;
  logic [1:0]        lane_size_s;
  logic [2:0]        lane_idx_s;
  logic [63:0]       lane_load_s, lane_store_s;
  logic [7:0]        lane_be_s;
  logic              is_lui_s, is_store_s, is_mem_s, misalign_s, timeout_s;

  assign ea_full_s  = base + {{32{offset[31]}}, offset};
  assign ea_s       = ea_full_s[ADDR_W-1:0];
  assign is_lui_s   = (unit == UNIT_LOAD_S) && (op == SIZE_D);
  assign is_store_s = (unit == UNIT_STORE);
  assign is_mem_s   = (unit == UNIT_LOAD_Z) || ((unit == UNIT_LOAD_S) && (op != SIZE_D)) || is_store_s;
  assign misalign_s = (ALIGN_CHECK != 0) && ((ea_s[2:0] & size_mask(op)) != 3'b000);
  assign timeout_s  = (TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LAST);

  // Lanes follow the incoming request at dispatch and the latched one while waiting.
  always_comb begin
    if (state_r == ST_IDLE) begin
      lane_size_s = op;
      lane_idx_s  = ea_s[2:0];
    end else begin
      lane_size_s = op_r;
      lane_idx_s  = ea_r[2:0];
    end
  end

  ex_mem_lane u_lane (
    .size       (lane_size_s),
    .lane       (lane_idx_s),
    .sext       (sext_r),
    .load_din   (dmem_din),
    .store_din  (data),
    .load_data  (lane_load_s),
    .store_data (lane_store_s),
    .be         (lane_be_s)
  );

  // Main FSM: dispatch, bus wait with timeout, result hand-off and stall hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      op_r         <= '0;
      sext_r       <= 1'b0;
      rd_r         <= '0;
      ea_r         <= '0;
      cnt_r        <= '0;
      out_r        <= '0;
      dout_r       <= '0;
      addr_r       <= '0;
      fault_addr_r <= '0;
      be_r         <= '0;
      width_r      <= '0;
      cause_r      <= '0;
      rd_out_r     <= '0;
      valid_r      <= 1'b0;
      fault_r      <= 1'b0;
      rstrobe_r    <= 1'b0;
      wstrobe_r    <= 1'b0;
    end else begin
      rstrobe_r <= 1'b0;
      wstrobe_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid_r && stall) begin
            state_r <= ST_HOLD;
          end else begin
            valid_r <= 1'b0;
            fault_r <= 1'b0;
            cause_r <= CAUSE_NONE;
            if (ex_enable && (is_lui_s || is_mem_s)) begin
              op_r   <= op;
              sext_r <= (unit == UNIT_LOAD_S);
              rd_r   <= rd_in_rn;
              ea_r   <= ea_s;
              if (is_lui_s) begin
                out_r    <= {offset, 32'h0};
                rd_out_r <= rd_in_rn;
                valid_r  <= 1'b1;
              end else if (misalign_s) begin
                out_r        <= '0;
                rd_out_r     <= '0;
                valid_r      <= 1'b1;
                fault_r      <= 1'b1;
                cause_r      <= CAUSE_MISALIGN;
                fault_addr_r <= ea_s;
              end else begin
                addr_r  <= {ea_s[ADDR_W-1:3], 3'b000};
                be_r    <= lane_be_s;
                width_r <= op;
                dout_r  <= is_store_s ? lane_store_s : 64'h0;
                cnt_r   <= '0;
                if (is_store_s) begin
                  wstrobe_r <= 1'b1;
                  state_r   <= ST_WRITE_WAIT;
                end else begin
                  rstrobe_r <= 1'b1;
                  state_r   <= ST_READ_WAIT;
                end
              end
            end
          end
        end
        ST_READ_WAIT, ST_WRITE_WAIT: begin
          // Completion takes priority over a timeout expiring in the same cycle.
          if (dmem_cycle_complete) begin
            valid_r  <= 1'b1;
            state_r  <= ST_IDLE;
            out_r    <= (state_r == ST_READ_WAIT) ? lane_load_s : 64'h0;
            rd_out_r <= (state_r == ST_READ_WAIT) ? rd_r : 6'd0;
          end else if (timeout_s) begin
            valid_r      <= 1'b1;
            fault_r      <= 1'b1;
            cause_r      <= CAUSE_TIMEOUT;
            fault_addr_r <= ea_r;
            rd_out_r     <= '0;
            out_r        <= '0;
            state_r      <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            valid_r <= 1'b0;
            fault_r <= 1'b0;
            cause_r <= CAUSE_NONE;
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign ex_busy      = ex_enable | (state_r != ST_IDLE) | (valid_r & stall);
  assign out          = out_r;
  assign valid        = valid_r;
  assign rd_out_rn    = rd_out_r;
  assign fault        = fault_r;
  assign fault_cause  = cause_r;
  assign fault_addr   = fault_addr_r;
  assign dmem_addr    = addr_r;
  assign dmem_dout    = dout_r;
  assign dmem_be      = be_r;
  assign dmem_width   = width_r;
  assign dmem_rstrobe = rstrobe_r;
  assign dmem_wstrobe = wstrobe_r;

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Directed bench for ex_mem_lsu: a vector table of single accesses plus
// hand-written sequences for reset, timeout, stall hold and reset mid-access.
module tb_ex_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] dmem_din, dmem_dout, dmem_addr, fault_addr;
  logic [7:0]  dmem_be;
  logic [1:0]  dmem_width, fault_cause;
  logic        dmem_rstrobe, dmem_wstrobe, dmem_cycle_complete;
  logic [63:0] base, data, out;
  logic [31:0] offset;
  logic        ex_enable, ex_busy, valid, stall, fault;
  logic [5:0]  rd_in_rn, rd_out_rn;
  logic [2:0]  unit;
  logic [1:0]  op;

  int n_cmp = 0;
  int n_fail = 0;

  ex_mem_lsu #(.ADDR_W(64), .TIMEOUT_CYCLES(4), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_din(dmem_din), .dmem_dout(dmem_dout), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_width(dmem_width), .dmem_rstrobe(dmem_rstrobe), .dmem_wstrobe(dmem_wstrobe),
    .dmem_cycle_complete(dmem_cycle_complete),
    .base(base), .data(data), .offset(offset), .out(out),
    .ex_enable(ex_enable), .ex_busy(ex_busy), .rd_in_rn(rd_in_rn), .unit(unit), .op(op),
    .rd_out_rn(rd_out_rn), .valid(valid), .stall(stall), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  unit;
    logic [1:0]  op;
    logic [63:0] base;
    logic [31:0] offset;
    logic [63:0] data;
    logic [5:0]  rd;
    logic [63:0] din;
    logic        rstb;
    logic        wstb;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] dout;
    logic        valid;
    logic [63:0] out;
    logic [5:0]  rd_out;
    logic        fault;
    logic [1:0]  cause;
    logic [63:0] faddr;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] u, input logic [1:0] o, input logic [63:0] b,
                       input logic [31:0] off, input logic [63:0] d, input logic [5:0] rd);
    unit = u; op = o; base = b; offset = off; data = d; rd_in_rn = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'd5, 2'd1, 64'h1000, 32'h4, 64'h0, 6'd7, 64'h0000_0000_8000_0001,
                 1'b1, 1'b0, 64'h1000, 8'h0F, 64'h0, 1'b1, 64'hFFFF_FFFF_8000_0001, 6'd7, 1'b0, 2'd0, 64'h0};
    vecs[1]  = '{3'd4, 2'd1, 64'h1000, 32'h4, 64'h0, 6'd8, 64'h0000_0000_8000_0001,
                 1'b1, 1'b0, 64'h1000, 8'h0F, 64'h0, 1'b1, 64'h0000_0000_8000_0001, 6'd8, 1'b0, 2'd0, 64'h0};
    vecs[2]  = '{3'd4, 2'd3, 64'h2000, 32'h2, 64'h0, 6'd10, 64'h0011_2233_4455_6677,
                 1'b1, 1'b0, 64'h2000, 8'h20, 64'h0, 1'b1, 64'h22, 6'd10, 1'b0, 2'd0, 64'h0};
    vecs[3]  = '{3'd5, 2'd3, 64'h2000, 32'h7, 64'h0, 6'd11, 64'h0000_0000_0000_00F0,
                 1'b1, 1'b0, 64'h2000, 8'h01, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 6'd11, 1'b0, 2'd0, 64'h0};
    vecs[4]  = '{3'd5, 2'd2, 64'h3000, 32'hFFFF_FFFE, 64'h0, 6'd12, 64'h0000_0000_0000_8001,
                 1'b1, 1'b0, 64'h2FF8, 8'h03, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 6'd12, 1'b0, 2'd0, 64'h0};
    vecs[5]  = '{3'd4, 2'd0, 64'h4000, 32'h8, 64'h0, 6'd13, 64'h0123_4567_89AB_CDEF,
                 1'b1, 1'b0, 64'h4008, 8'hFF, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF, 6'd13, 1'b0, 2'd0, 64'h0};
    vecs[6]  = '{3'd6, 2'd3, 64'h2000, 32'h3, 64'h1234_5678_9ABC_DEAB, 6'd9, 64'h0,
                 1'b0, 1'b1, 64'h2000, 8'h10, 64'hABAB_ABAB_ABAB_ABAB, 1'b1, 64'h0, 6'd0, 1'b0, 2'd0, 64'h0};
    vecs[7]  = '{3'd6, 2'd1, 64'h5000, 32'h0, 64'hDEAD_BEEF_CAFE_F00D, 6'd9, 64'h0,
                 1'b0, 1'b1, 64'h5000, 8'hF0, 64'hCAFE_F00D_CAFE_F00D, 1'b1, 64'h0, 6'd0, 1'b0, 2'd0, 64'h0};
    vecs[8]  = '{3'd6, 2'd2, 64'h5000, 32'h2, 64'h0000_0000_0000_1234, 6'd9, 64'h0,
                 1'b0, 1'b1, 64'h5000, 8'h30, 64'h1234_1234_1234_1234, 1'b1, 64'h0, 6'd0, 1'b0, 2'd0, 64'h0};
    vecs[9]  = '{3'd5, 2'd0, 64'h0, 32'h1234_5678, 64'h0, 6'd3, 64'h0,
                 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 1'b1, 64'h1234_5678_0000_0000, 6'd3, 1'b0, 2'd0, 64'h0};
    vecs[10] = '{3'd4, 2'd2, 64'h3000, 32'h1, 64'h0, 6'd14, 64'h0,
                 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 1'b1, 64'h0, 6'd0, 1'b1, 2'd1, 64'h3001};
    vecs[11] = '{3'd6, 2'd1, 64'h1000, 32'h2, 64'h55, 6'd15, 64'h0,
                 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 1'b1, 64'h0, 6'd0, 1'b1, 2'd1, 64'h1002};
    vecs[12] = '{3'd2, 2'd0, 64'h6000, 32'h0, 64'h0, 6'd16, 64'h0,
                 1'b0, 1'b0, 64'h0, 8'h0, 64'h0, 1'b0, 64'h0, 6'd0, 1'b0, 2'd0, 64'h0};

    rst_n = 1'b1; ex_enable = 1'b0; stall = 1'b0; dmem_cycle_complete = 1'b0; dmem_din = 64'h0;
    drive(3'd0, 2'd0, 64'h0, 32'h0, 64'h0, 6'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_out", out, 64'h0);
    chk("rst_rd", 64'(rd_out_rn), 64'h0);
    chk("rst_fault", {62'h0, fault_cause} | 64'(fault), 64'h0);
    chk("rst_faddr", fault_addr, 64'h0);
    chk("rst_addr", dmem_addr, 64'h0);
    chk("rst_be", 64'(dmem_be), 64'h0);
    chk("rst_strobes", {62'h0, dmem_rstrobe, dmem_wstrobe}, 64'h0);
    chk("rst_busy", 64'(ex_busy), 64'h0);

    // First dispatch accepted on the very first edge after reset release.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(3'd4, 2'd0, 64'h8000, 32'h0, 64'h0, 6'd2);
    ex_enable = 1'b1;
    tick();
    ex_enable = 1'b0;
    chk("first_accept_rstrobe", 64'(dmem_rstrobe), 64'h1);
    dmem_din = 64'hA5A5_5A5A_0F0F_F0F0; dmem_cycle_complete = 1'b1;
    tick();
    dmem_cycle_complete = 1'b0;
    chk("first_valid", 64'(valid), 64'h1);
    chk("first_out", out, 64'hA5A5_5A5A_0F0F_F0F0);
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].unit, vecs[i].op, vecs[i].base, vecs[i].offset, vecs[i].data, vecs[i].rd);
      ex_enable = 1'b1;
      tick();
      ex_enable = 1'b0;
      chk($sformatf("v%0d_rstrobe", i), 64'(dmem_rstrobe), 64'(vecs[i].rstb));
      chk($sformatf("v%0d_wstrobe", i), 64'(dmem_wstrobe), 64'(vecs[i].wstb));
      if (vecs[i].rstb || vecs[i].wstb) begin
        chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].addr);
        chk($sformatf("v%0d_be", i), 64'(dmem_be), 64'(vecs[i].be));
        chk($sformatf("v%0d_width", i), 64'(dmem_width), 64'(vecs[i].op));
        if (vecs[i].wstb) chk($sformatf("v%0d_dout", i), dmem_dout, vecs[i].dout);
        dmem_din = vecs[i].din; dmem_cycle_complete = 1'b1;
        tick();
        dmem_cycle_complete = 1'b0;
        chk($sformatf("v%0d_strobe_once", i), {62'h0, dmem_rstrobe, dmem_wstrobe}, 64'h0);
      end
      chk($sformatf("v%0d_valid", i), 64'(valid), 64'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_rd_out", i), 64'(rd_out_rn), 64'(vecs[i].rd_out));
        chk($sformatf("v%0d_fault", i), 64'(fault), 64'(vecs[i].fault));
        chk($sformatf("v%0d_cause", i), 64'(fault_cause), 64'(vecs[i].cause));
        if (vecs[i].fault) chk($sformatf("v%0d_faddr", i), fault_addr, vecs[i].faddr);
        else if (!vecs[i].wstb) chk($sformatf("v%0d_out", i), out, vecs[i].out);
      end
      tick();
      chk($sformatf("v%0d_valid_pulse", i), 64'(valid), 64'h0);
      chk($sformatf("v%0d_busy_idle", i), 64'(ex_busy), 64'h0);
    end

    // Read that never completes: fault after four wait cycles, late complete ignored.
    drive(3'd4, 2'd0, 64'h9000, 32'h10, 64'h0, 6'd5);
    ex_enable = 1'b1;
    tick();
    ex_enable = 1'b0;
    chk("to_rstrobe", 64'(dmem_rstrobe), 64'h1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("to_wait%0d_valid", k), 64'(valid), 64'h0);
    end
    tick();
    chk("to_valid", 64'(valid), 64'h1);
    chk("to_fault", 64'(fault), 64'h1);
    chk("to_cause", 64'(fault_cause), 64'h2);
    chk("to_faddr", fault_addr, 64'h9010);
    chk("to_rd", 64'(rd_out_rn), 64'h0);
    chk("to_busy", 64'(ex_busy), 64'h0);
    dmem_din = 64'h1111; dmem_cycle_complete = 1'b1;
    tick();
    dmem_cycle_complete = 1'b0;
    chk("to_late_valid", 64'(valid), 64'h0);
    chk("to_late_fault", 64'(fault), 64'h0);

    // Complete arriving in the cycle the timeout would expire wins.
    drive(3'd5, 2'd1, 64'hA000, 32'h4, 64'h0, 6'd6);
    ex_enable = 1'b1;
    tick();
    ex_enable = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("cw_wait%0d_valid", k), 64'(valid), 64'h0);
    end
    dmem_din = 64'h0000_0000_7FFF_FFFF; dmem_cycle_complete = 1'b1;
    tick();
    dmem_cycle_complete = 1'b0;
    chk("cw_valid", 64'(valid), 64'h1);
    chk("cw_fault", 64'(fault), 64'h0);
    chk("cw_out", out, 64'h0000_0000_7FFF_FFFF);
    chk("cw_rd", 64'(rd_out_rn), 64'h6);
    tick();

    // LUI with stall held for three cycles: valid held three cycles, busy throughout.
    drive(3'd5, 2'd0, 64'h0, 32'h1234_5678, 64'h0, 6'd21);
    ex_enable = 1'b1; stall = 1'b1;
    #1;
    chk("lui_busy_dispatch", 64'(ex_busy), 64'h1);
    @(posedge clk); #1;
    ex_enable = 1'b0;
    #1;
    chk("lui_valid_c1", 64'(valid), 64'h1);
    chk("lui_out_c1", out, 64'h1234_5678_0000_0000);
    chk("lui_rd_c1", 64'(rd_out_rn), 64'd21);
    chk("lui_busy_c1", 64'(ex_busy), 64'h1);
    tick();
    chk("lui_valid_c2", 64'(valid), 64'h1);
    chk("lui_out_c2", out, 64'h1234_5678_0000_0000);
    chk("lui_busy_c2", 64'(ex_busy), 64'h1);
    tick();
    stall = 1'b0;
    #1;
    chk("lui_valid_c3", 64'(valid), 64'h1);
    chk("lui_out_c3", out, 64'h1234_5678_0000_0000);
    chk("lui_rd_c3", 64'(rd_out_rn), 64'd21);
    chk("lui_busy_c3", 64'(ex_busy), 64'h1);
    tick();
    chk("lui_valid_end", 64'(valid), 64'h0);
    chk("lui_busy_end", 64'(ex_busy), 64'h0);

    // Reset pulse in READ_WAIT abandons the access; the next load completes normally.
    drive(3'd4, 2'd3, 64'hB000, 32'h5, 64'h0, 6'd4);
    ex_enable = 1'b1;
    tick();
    ex_enable = 1'b0;
    chk("mid_rstrobe", 64'(dmem_rstrobe), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobe", 64'(dmem_rstrobe), 64'h0);
    chk("mid_rst_addr", dmem_addr, 64'h0);
    chk("mid_rst_be", 64'(dmem_be), 64'h0);
    chk("mid_rst_busy", 64'(ex_busy), 64'h0);
    #2 rst_n = 1'b1;
    tick();
    ex_enable = 1'b1;
    tick();
    ex_enable = 1'b0;
    chk("post_rstrobe", 64'(dmem_rstrobe), 64'h1);
    chk("post_be", 64'(dmem_be), 64'h04);
    dmem_din = 64'h0000_0000_00CC_0000; dmem_cycle_complete = 1'b1;
    tick();
    dmem_cycle_complete = 1'b0;
    chk("post_valid", 64'(valid), 64'h1);
    chk("post_out", out, 64'hCC);
    chk("post_rd", 64'(rd_out_rn), 64'h4);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
